// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - buffer-side and chunk-side signals of word_serializer
interface word_serializer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2
);
  logic                 buf_empty;
  logic [IN_WIDTH-1:0]  buf_data;
  logic                 buf_clear;
  logic                 step;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 idle;

  modport master (
    input  buf_empty, buf_data, step,
    output buf_clear, out_valid, out_data, out_last, idle
  );

  modport slave (
    output buf_empty, buf_data, step,
    input  buf_clear, out_valid, out_data, out_last, idle
  );
endinterface

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - drains single_word_buffer and emits each word as step-paced chunks
// A word waiting at the end of the current one is reloaded on the final step, so words stream without a bubble.
module word_serializer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst,
  word_serializer_if.master  bus
);
  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [IN_WIDTH-1:0]  r_sr;
  logic                 r_valid;
  logic [OUT_WIDTH-1:0] r_data;

  logic w_at_last;
  logic w_take;

  function automatic logic [OUT_WIDTH-1:0] chunk(input logic [IN_WIDTH-1:0] word,
                                                 input logic [IW-1:0] k);
    int pos;
    pos = (MSB_FIRST != 0) ? (N - 1 - int'(k)) : int'(k);
    return OUT_WIDTH'(word >> (pos * OUT_WIDTH));
  endfunction

  assign w_at_last = (r_state == S_SHIFT) && bus.step && (r_idx == LAST_IDX);
  assign w_take    = !bus.buf_empty && ((r_state == S_IDLE) || w_at_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sr    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_take) begin
      r_state <= S_SHIFT;
      r_sr    <= bus.buf_data;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_data  <= chunk(bus.buf_data, '0);
    end else if (r_state == S_SHIFT && bus.step) begin
      if (r_idx == LAST_IDX) begin
        // Underrun: nothing waiting, so drop back to idle with outputs cleared.
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_data <= chunk(r_sr, r_idx + 1'b1);
      end
    end
  end

  assign bus.buf_clear = !rst && w_take;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_valid && (r_idx == LAST_IDX);
  assign bus.idle      = (r_state == S_IDLE);
endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed vector table on LSB/MSB-first instances, then random scoreboard run
module tb_word_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wdata;
  logic       step;

  always #5 clk = ~clk;

  word_serializer_if #(.IN_WIDTH(8), .OUT_WIDTH(2)) if0 ();
  word_serializer_if #(.IN_WIDTH(8), .OUT_WIDTH(2)) if1 ();

  word_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  word_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // single_word_buffer models: a write wins over a clear in the same cycle
  logic       full0 = 1'b0, full1 = 1'b0;
  logic [7:0] bdata0 = 8'h00, bdata1 = 8'h00;

  always @(posedge clk) begin
    if (wr) begin
      full0 <= 1'b1; bdata0 <= wdata;
    end else if (if0.buf_clear) begin
      full0 <= 1'b0;
    end
    if (wr) begin
      full1 <= 1'b1; bdata1 <= wdata;
    end else if (if1.buf_clear) begin
      full1 <= 1'b0;
    end
  end

  assign if0.buf_empty = !full0;
  assign if0.buf_data  = bdata0;
  assign if0.step      = step;
  assign if1.buf_empty = !full1;
  assign if1.buf_data  = bdata1;
  assign if1.step      = step;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       step;
    logic       v;
    logic [1:0] dl;
    logic [1:0] dm;
    logic       last;
    logic       idle;
    logic       clr;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic add(input logic r, input logic w, input logic [7:0] wd, input logic s,
                     input logic v, input logic [1:0] dl, input logic [1:0] dm,
                     input logic l, input logic i, input logic c);
    vec_t e;
    e = '{rst: r, wr: w, wdata: wd, step: s, v: v, dl: dl, dm: dm, last: l, idle: i, clr: c};
    tbl.push_back(e);
  endtask

  task automatic check_row(input int row, input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row%0d %s {valid,data,last,idle,clear} got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
               row, tag, act[5], act[4:3], act[2], act[1], act[0],
               exp[5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic pop_check(input string tag, inout logic [2:0] q[$], input logic [1:0] d, input logic l);
    logic [2:0] e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s chunk emitted with empty scoreboard got data=%0d last=%0d", tag, d, l);
    end else begin
      e = q.pop_front();
      if ({d, l} !== e) begin
        n_err++;
        $display("FAIL %s chunk got data=%0d last=%0d want data=%0d last=%0d", tag, d, l, e[2:1], e[0]);
      end
    end
  endtask

  initial begin
    int words;
    int cyc;
    logic [7:0] w;

    // Reset with a word already buffered, single word at one step per 4 cycles
    add(1,1,8'hB4,0, 0,0,0,0,1,0);
    add(1,0,8'h00,0, 0,0,0,0,1,0);
    add(0,0,8'h00,0, 0,0,0,0,1,1);
    add(0,0,8'h00,0, 1,0,2,0,0,0);
    add(0,0,8'h00,0, 1,0,2,0,0,0);
    add(0,0,8'h00,1, 1,0,2,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,8'h00,0, 1,1,3,0,0,0);
    add(0,0,8'h00,1, 1,1,3,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,8'h00,0, 1,3,1,0,0,0);
    add(0,0,8'h00,1, 1,3,1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,8'h00,0, 1,2,0,1,0,0);
    add(0,0,8'h00,1, 1,2,0,1,0,0);
    add(0,0,8'h00,0, 0,0,0,0,1,0);
    // Back-to-back B4,1E,5A; 5A is written in the same cycle 1E is cleared
    add(0,1,8'hB4,0, 0,0,0,0,1,0);
    add(0,0,8'h00,0, 0,0,0,0,1,1);
    add(0,1,8'h1E,0, 1,0,2,0,0,0);
    add(0,0,8'h00,1, 1,0,2,0,0,0);
    add(0,0,8'h00,1, 1,1,3,0,0,0);
    add(0,0,8'h00,1, 1,3,1,0,0,0);
    add(0,0,8'h00,0, 1,2,0,1,0,0);
    add(0,1,8'h5A,1, 1,2,0,1,0,1);
    add(0,0,8'h00,1, 1,2,0,0,0,0);
    add(0,0,8'h00,1, 1,3,1,0,0,0);
    add(0,0,8'h00,1, 1,1,3,0,0,0);
    add(0,0,8'h00,1, 1,0,2,1,0,1);
    add(0,0,8'h00,1, 1,2,1,0,0,0);
    add(0,0,8'h00,1, 1,2,1,0,0,0);
    add(0,0,8'h00,1, 1,1,2,0,0,0);
    add(0,0,8'h00,1, 1,1,2,1,0,0);
    add(0,0,8'h00,1, 0,0,0,0,1,0);
    // Reset after chunk 2, then a fresh word starts at chunk 0
    add(0,1,8'hB4,0, 0,0,0,0,1,0);
    add(0,0,8'h00,0, 0,0,0,0,1,1);
    add(0,1,8'h1E,1, 1,0,2,0,0,0);
    add(0,0,8'h00,1, 1,1,3,0,0,0);
    add(1,0,8'h00,0, 1,3,1,0,0,0);
    add(0,0,8'h00,0, 0,0,0,0,1,1);
    add(0,0,8'h00,0, 1,2,0,0,0,0);
    add(0,0,8'h00,1, 1,2,0,0,0,0);
    add(0,0,8'h00,1, 1,3,1,0,0,0);
    add(0,0,8'h00,1, 1,1,3,0,0,0);
    add(0,0,8'h00,1, 1,0,2,1,0,0);
    add(0,0,8'h00,0, 0,0,0,0,1,0);

    rst = 1'b1; wr = 1'b0; wdata = 8'h00; step = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; wr = tbl[i].wr; wdata = tbl[i].wdata; step = tbl[i].step;
      #1;
      check_row(i, "lsb", {if0.out_valid, if0.out_data, if0.out_last, if0.idle, if0.buf_clear},
                {tbl[i].v, tbl[i].dl, tbl[i].last, tbl[i].idle, tbl[i].clr});
      check_row(i, "msb", {if1.out_valid, if1.out_data, if1.out_last, if1.idle, if1.buf_clear},
                {tbl[i].v, tbl[i].dm, tbl[i].last, tbl[i].idle, tbl[i].clr});
    end

    // Random words and step spacing; writes land only when empty or on a clear cycle
    words = 0;
    cyc = 0;
    while ((words < 100 || q0.size() != 0 || q1.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      wr = 1'b0;
      step = ($urandom_range(0, 2) == 0);
      #1;
      if (if0.out_valid && step) pop_check("lsb", q0, if0.out_data, if0.out_last);
      if (if1.out_valid && step) pop_check("msb", q1, if1.out_data, if1.out_last);
      if (words < 100 && (!full0 || if0.buf_clear) && $urandom_range(0, 1) == 1) begin
        w = 8'($urandom);
        wr = 1'b1;
        wdata = w;
        for (int k = 0; k < 4; k++) begin
          q0.push_back({w[2*k +: 2], k == 3});
          q1.push_back({w[2*(3-k) +: 2], k == 3});
        end
        words++;
      end
    end
    n_vec++;
    if (words != 100 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain words=%0d pending lsb=%0d msb=%0d want words=100 pending 0",
               words, q0.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
